// File: rtl/wb_pkg.sv
// Writeback arbiter shared widths, sizes and the held-result record.
// Imported by wb_rr_pick and wb_arbiter.
package wb_pkg;
  localparam int NREQ   = 4;
  localparam int NPORT  = 3;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int ROB_W  = 6;

  typedef struct packed {
    logic [REG_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic [ROB_W-1:0]  rob;
  } wb_entry_t;
endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin pick of up to NPORT holders onto write ports, zero latency.
// Optional WB_WAW_FILTER_EN skips holders whose waddr was already granted this cycle.
module wb_rr_pick
  import wb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NPORT = 3
) (
  input  logic [NREQ-1:0]             hold_v,
  input  logic [1:0]                  rr_ptr,
  input  logic [NREQ-1:0][REG_W-1:0]  hold_waddr,
  output logic [NPORT-1:0][NREQ-1:0]  sel,
  output logic [NPORT-1:0]            port_v,
  output logic [NREQ-1:0]             grant,
  output logic [1:0]                  rr_next
);
  logic [1:0] idx;
  logic [2:0] cnt;
  logic       take;
`ifdef WB_WAW_FILTER_EN
  logic [(1<<REG_W)-1:0] used;
`endif

  always_comb begin
    sel     = '0;
    port_v  = '0;
    grant   = '0;
    rr_next = rr_ptr;
    cnt     = '0;
    idx     = '0;
    take    = 1'b0;
`ifdef WB_WAW_FILTER_EN
    used    = '0;
`endif
    for (int j = 0; j < NREQ; j++) begin
      idx  = rr_ptr + j[1:0];
      take = hold_v[idx] && (cnt < 3'(NPORT));
`ifdef WB_WAW_FILTER_EN
      // skipped same-address holders do not consume a port
      if (used[hold_waddr[idx]]) take = 1'b0;
`endif
      if (take) begin
        grant[idx]           = 1'b1;
        sel[cnt[1:0]][idx]   = 1'b1;
        port_v[cnt[1:0]]     = 1'b1;
        rr_next              = idx + 2'd1;
`ifdef WB_WAW_FILTER_EN
        used[hold_waddr[idx]] = 1'b1;
`endif
        cnt                  = cnt + 3'd1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit one-entry buffers, round-robin onto 3 registered RF write ports
// (push-to-wen 2 cycles); req_ready drops while a buffer holds an ungranted result or on flush.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NPORT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*REG_W-1:0]    req_waddr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*ROB_W-1:0]    req_rob,
  output logic                     wen0,
  output logic                     wen1,
  output logic                     wen2,
  output logic [REG_W-1:0]         waddr0,
  output logic [REG_W-1:0]         waddr1,
  output logic [REG_W-1:0]         waddr2,
  output logic [DATA_W-1:0]        wdata0,
  output logic [DATA_W-1:0]        wdata1,
  output logic [DATA_W-1:0]        wdata2,
  output logic [ROB_W-1:0]         wrob0,
  output logic [ROB_W-1:0]         wrob1,
  output logic [ROB_W-1:0]         wrob2
);
  wb_entry_t                  hold [NREQ];
  logic [NREQ-1:0]            hold_v;
  logic [NREQ-1:0]            grant;
  logic [NREQ-1:0]            push;
  logic [1:0]                 rr_ptr;
  logic [1:0]                 rr_next;
  logic [NREQ-1:0][REG_W-1:0] hold_waddr;
  logic [NPORT-1:0][NREQ-1:0] sel;
  logic [NPORT-1:0]           port_v;
  wb_entry_t                  port_ent [NPORT];
  logic [NPORT-1:0]           wen_q;
  wb_entry_t                  out_q [NPORT];

  always_comb begin
    for (int i = 0; i < NREQ; i++) hold_waddr[i] = hold[i].waddr;
  end

  wb_rr_pick #(.NREQ(NREQ), .NPORT(NPORT)) u_pick (
    .hold_v     (hold_v),
    .rr_ptr     (rr_ptr),
    .hold_waddr (hold_waddr),
    .sel        (sel),
    .port_v     (port_v),
    .grant      (grant),
    .rr_next    (rr_next)
  );

  // a granted buffer drains this edge, so it can accept a new result in the same cycle
  assign req_ready = {NREQ{~flush}} & (~hold_v | grant);
  assign push      = req_valid & req_ready;

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      port_ent[p] = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (sel[p][i]) port_ent[p] = hold[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v <= '0;
      rr_ptr <= '0;
      wen_q  <= '0;
      for (int p = 0; p < NPORT; p++) out_q[p] <= '0;
      for (int i = 0; i < NREQ; i++) hold[i] <= '0;
    end else if (flush) begin
      hold_v <= '0;
      wen_q  <= '0;
    end else begin
      rr_ptr <= rr_next;
      wen_q  <= port_v;
      for (int p = 0; p < NPORT; p++) begin
        if (port_v[p]) out_q[p] <= port_ent[p];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (push[i]) begin
          hold_v[i] <= 1'b1;
          hold[i]   <= '{waddr: req_waddr[i*REG_W +: REG_W],
                         wdata: req_wdata[i*DATA_W +: DATA_W],
                         rob:   req_rob[i*ROB_W +: ROB_W]};
        end else if (grant[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  assign wen0   = wen_q[0];
  assign wen1   = wen_q[1];
  assign wen2   = wen_q[2];
  assign waddr0 = out_q[0].waddr;
  assign waddr1 = out_q[1].waddr;
  assign waddr2 = out_q[2].waddr;
  assign wdata0 = out_q[0].wdata;
  assign wdata1 = out_q[1].wdata;
  assign wdata2 = out_q[2].wdata;
  assign wrob0  = out_q[0].rob;
  assign wrob1  = out_q[1].rob;
  assign wrob2  = out_q[2].rob;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a per-cycle reference model queues expected write ports,
// a monitor compares them after each edge; req_ready is checked as stimulus is applied.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [11:0] req_waddr = '0;
  logic [63:0] req_wdata = '0;
  logic [23:0] req_rob = '0;
  logic        wen0, wen1, wen2;
  logic [2:0]  waddr0, waddr1, waddr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [5:0]  wrob0, wrob1, wrob2;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_rob(req_rob),
    .wen0(wen0), .wen1(wen1), .wen2(wen2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .wrob0(wrob0), .wrob1(wrob1), .wrob2(wrob2)
  );

  typedef struct packed {
    logic [2:0]       wen;
    logic [2:0][2:0]  a;
    logic [2:0][15:0] d;
    logic [2:0][5:0]  r;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // reference state: what each unit is holding, scan start, last value on each port
  bit          m_hv [4];
  logic [2:0]  m_a  [4];
  logic [15:0] m_d  [4];
  logic [5:0]  m_r  [4];
  int          m_ptr = 0;
  exp_t        m_out = '0;

  task automatic step(input logic [3:0] v, input logic [11:0] a, input logic [63:0] d,
                      input logic [23:0] r, input logic f, input logic rs);
    int   order[$];
    int   gl[$];
    bit   taken [8];
    bit   granted [4];
    logic [3:0] rdy;
    @(negedge clk);
    req_valid = v; req_waddr = a; req_wdata = d; req_rob = r; flush = f; rst = rs;
    for (int k = 0; k < 8; k++) taken[k] = 0;
    for (int u = 0; u < 4; u++) granted[u] = 0;
    // holders listed oldest-priority first, then the first three (distinct regs if filtered)
    for (int k = 0; k < 4; k++) if (m_hv[(m_ptr + k) % 4]) order.push_back((m_ptr + k) % 4);
    foreach (order[n]) begin
      if (gl.size() < 3) begin
`ifdef WB_WAW_FILTER_EN
        if (taken[m_a[order[n]]]) continue;
`endif
        gl.push_back(order[n]);
        granted[order[n]] = 1;
        taken[m_a[order[n]]] = 1;
      end
    end
    for (int u = 0; u < 4; u++) rdy[u] = !f && (!m_hv[u] || granted[u]);
    #1;
    total++;
    if (req_ready !== rdy) begin
      bad++;
      $display("FAIL req_ready t=%0t got=%b want=%b", $time, req_ready, rdy);
    end
    if (rs) begin
      for (int u = 0; u < 4; u++) begin m_hv[u] = 0; m_a[u] = 0; m_d[u] = 0; m_r[u] = 0; end
      m_ptr = 0;
      m_out = '0;
    end else if (f) begin
      for (int u = 0; u < 4; u++) m_hv[u] = 0;
      m_out.wen = '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (p < gl.size()) begin
          m_out.wen[p] = 1'b1;
          m_out.a[p] = m_a[gl[p]];
          m_out.d[p] = m_d[gl[p]];
          m_out.r[p] = m_r[gl[p]];
        end else begin
          m_out.wen[p] = 1'b0;
        end
      end
      if (gl.size() > 0) m_ptr = (gl[gl.size()-1] + 1) % 4;
      for (int u = 0; u < 4; u++) begin
        if (v[u] && rdy[u]) begin
          m_hv[u] = 1;
          m_a[u] = a[u*3 +: 3];
          m_d[u] = d[u*16 +: 16];
          m_r[u] = r[u*6 +: 6];
        end else if (granted[u]) begin
          m_hv[u] = 0;
        end
      end
    end
    expq.push_back(m_out);
  endtask

  task automatic rand_step(input int pv, input bit distinct, input int pflush, input int prst);
    logic [3:0]  v;
    logic [11:0] a;
    logic [63:0] d;
    logic [23:0] r;
    for (int u = 0; u < 4; u++) begin
      v[u] = ($urandom_range(99) < pv);
      a[u*3 +: 3] = distinct ? 3'(u + 2) : 3'($urandom_range(7));
      d[u*16 +: 16] = 16'($urandom);
      r[u*6 +: 6] = 6'($urandom);
    end
    step(v, a, d, r, $urandom_range(99) < pflush, $urandom_range(99) < prst);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // monitor: every cycle the write ports must match the model's snapshot
  initial begin
    exp_t e;
    logic [2:0]       gw;
    logic [2:0][2:0]  ga;
    logic [2:0][15:0] gd;
    logic [2:0][5:0]  gr;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        gw = {wen2, wen1, wen0};
        ga = {waddr2, waddr1, waddr0};
        gd = {wdata2, wdata1, wdata0};
        gr = {wrob2, wrob1, wrob0};
        for (int p = 0; p < 3; p++) begin
          total++;
          if (gw[p] !== e.wen[p] || ga[p] !== e.a[p] || gd[p] !== e.d[p] || gr[p] !== e.r[p]) begin
            bad++;
            $display("FAIL port%0d t=%0t got wen=%b a=%0d d=%h r=%0d want wen=%b a=%0d d=%h r=%0d",
                     p, $time, gw[p], ga[p], gd[p], gr[p], e.wen[p], e.a[p], e.d[p], e.r[p]);
          end
        end
      end
    end
  end

  initial begin
    step('0, '0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, '0, 1'b0, 1'b1);
    idle(1);
    // single result from unit 1: r3 / 0x1234 / rob 5
    step(4'b0010, 12'(3 << 3), 64'(64'h1234 << 16), 24'(5 << 6), 1'b0, 1'b0);
    idle(3);
    // all units every cycle, distinct regs, from a reset pointer
    step('0, '0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) rand_step(100, 1'b1, 0, 0);
    idle(3);
    // unit 2 back to back
    for (int k = 0; k < 6; k++)
      step(4'b0100, 12'(5 << 6), 64'(64'(16'hA000 + k) << 32), 24'(k << 12), 1'b0, 1'b0);
    idle(2);
    // flush while three units hold
    step(4'b0111, 12'h2c1, 64'h0003_0002_0001_0000, 24'h0a5a5a, 1'b0, 1'b0);
    step('0, '0, '0, '0, 1'b1, 1'b0);
    idle(3);
    // units 0 and 2 both to r4
    step('0, '0, '0, '0, 1'b0, 1'b1);
    step(4'b0101, 12'(4 | (4 << 6)), 64'h0000_bbbb_0000_aaaa, 24'(1 | (2 << 12)), 1'b0, 1'b0);
    idle(3);
    // reset with pending grants
    step(4'b1111, 12'hfac, 64'h1111_2222_3333_4444, 24'h123456, 1'b0, 1'b0);
    step(4'b1111, 12'h688, 64'h5555_6666_7777_8888, 24'h654321, 1'b0, 1'b1);
    idle(3);
    // random traffic with register collisions, occasional flush and reset
    for (int k = 0; k < 600; k++) rand_step(60, 1'b0, 3, 1);
    for (int k = 0; k < 200; k++) rand_step(95, 1'b0, 0, 0);
    idle(4);
    @(posedge clk);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
